dma_icb_arb: RTL and testbench

DMA_ICB_ARB -- requirements
Module: dma_icb_arb

---
 rtl/dma_icb_arb.sv | 153 +++++++++++++++
 tb/tb_dma_icb_arb.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_icb_arb.sv
// Two-master to one-slave ICB arbiter: round-robin command selection with a lock
// while the slave stalls, in-order response routing through a grant-id FIFO.
module dma_icb_arb #(
  parameter int OSTD_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          m0_icb_cmd_valid,
  input  logic                          m0_icb_cmd_read,
  input  logic [31:0]                   m0_icb_cmd_addr,
  input  logic [31:0]                   m0_icb_cmd_wdata,
  input  logic [3:0]                    m0_icb_cmd_wmask,
  output logic                          m0_icb_cmd_ready,
  output logic                          m0_icb_rsp_valid,
  output logic [31:0]                   m0_icb_rsp_rdata,
  output logic                          m0_icb_rsp_err,
  input  logic                          m0_icb_rsp_ready,
  input  logic                          m1_icb_cmd_valid,
  input  logic                          m1_icb_cmd_read,
  input  logic [31:0]                   m1_icb_cmd_addr,
  input  logic [31:0]                   m1_icb_cmd_wdata,
  input  logic [3:0]                    m1_icb_cmd_wmask,
  output logic                          m1_icb_cmd_ready,
  output logic                          m1_icb_rsp_valid,
  output logic [31:0]                   m1_icb_rsp_rdata,
  output logic                          m1_icb_rsp_err,
  input  logic                          m1_icb_rsp_ready,
  output logic                          s_icb_cmd_valid,
  output logic                          s_icb_cmd_read,
  output logic [31:0]                   s_icb_cmd_addr,
  output logic [31:0]                   s_icb_cmd_wdata,
  output logic [3:0]                    s_icb_cmd_wmask,
  input  logic                          s_icb_cmd_ready,
  input  logic                          s_icb_rsp_valid,
  input  logic                          s_icb_rsp_err,
  input  logic [31:0]                   s_icb_rsp_rdata,
  output logic                          s_icb_rsp_ready,
  output logic [$clog2(OSTD_DEPTH):0]   ost_cnt,
  output logic                          arb_err
);

  localparam int AW = $clog2(OSTD_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OSTD_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // Handshake rule on every channel: a beat transfers on a rising clk edge where
  // valid and ready are both 1; a master holds valid and payload until then.
  logic                  r_last;
  logic                  r_lock;
  logic                  r_lock_id;
  logic [OSTD_DEPTH-1:0] r_fifo;
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_cnt;
  logic                  r_arb_err;

  logic w_sel;
  logic w_sel_valid;
  logic w_full;
  logic w_empty;
  logic w_head;
  logic w_push;
  logic w_pop;

  // A stalled command keeps its master selected; otherwise ties go to the
  // master not granted last.
  always_comb begin
    w_sel = 1'b0;
    if (r_lock) begin
      w_sel = r_lock_id;
    end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
      w_sel = ~r_last;
    end else if (m1_icb_cmd_valid) begin
      w_sel = 1'b1;
    end
  end

  assign w_full      = (r_cnt == DEPTH_C);
  assign w_empty     = (r_cnt == '0);
  assign w_head      = r_fifo[r_rptr];
  assign w_sel_valid = w_sel ? m1_icb_cmd_valid : m0_icb_cmd_valid;

  assign s_icb_cmd_valid = w_sel_valid & ~w_full;
  assign s_icb_cmd_read  = w_sel ? m1_icb_cmd_read  : m0_icb_cmd_read;
  assign s_icb_cmd_addr  = w_sel ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
  assign s_icb_cmd_wdata = w_sel ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
  assign s_icb_cmd_wmask = w_sel ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

  // Ready is also qualified by the master's own valid so an idle port never sees ready.
  assign m0_icb_cmd_ready = ~w_sel & m0_icb_cmd_valid & s_icb_cmd_ready & ~w_full;
  assign m1_icb_cmd_ready =  w_sel & m1_icb_cmd_valid & s_icb_cmd_ready & ~w_full;

  assign w_push = s_icb_cmd_valid & s_icb_cmd_ready;

  assign m0_icb_rsp_valid = ~w_empty & ~w_head & s_icb_rsp_valid;
  assign m1_icb_rsp_valid = ~w_empty &  w_head & s_icb_rsp_valid;
  assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
  assign m1_icb_rsp_rdata = s_icb_rsp_rdata;
  assign m0_icb_rsp_err   = s_icb_rsp_err;
  assign m1_icb_rsp_err   = s_icb_rsp_err;

  // With nothing outstanding, stray responses are swallowed rather than stalling the slave.
  assign s_icb_rsp_ready = w_empty | (w_head ? m1_icb_rsp_ready : m0_icb_rsp_ready);
  assign w_pop           = ~w_empty & s_icb_rsp_valid & s_icb_rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last    <= 1'b1;
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
    end else if (w_push) begin
      r_last <= w_sel;
      r_lock <= 1'b0;
    end else if (s_icb_cmd_valid) begin
      r_lock    <= 1'b1;
      r_lock_id <= w_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= w_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_arb_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
      r_arb_err <= w_empty & s_icb_rsp_valid;
    end
  end

  assign ost_cnt = r_cnt;
  assign arb_err = r_arb_err;

endmodule

// File: tb/tb_dma_icb_arb.sv
// Bench for dma_icb_arb: directed scenarios plus random traffic, all checked
// against a queue-based model of grants and outstanding responses.
module tb_dma_icb_arb;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic        clk;
  logic        rst_n;
  logic        m_cmd_valid [2];
  logic        m_cmd_read  [2];
  logic [31:0] m_cmd_addr  [2];
  logic [31:0] m_cmd_wdata [2];
  logic [3:0]  m_cmd_wmask [2];
  logic        m_cmd_ready [2];
  logic        m_rsp_valid [2];
  logic [31:0] m_rsp_rdata [2];
  logic        m_rsp_err   [2];
  logic        m_rsp_ready [2];
  logic        s_cmd_valid, s_cmd_read, s_cmd_ready;
  logic [31:0] s_cmd_addr, s_cmd_wdata;
  logic [3:0]  s_cmd_wmask;
  logic        s_rsp_valid, s_rsp_err, s_rsp_ready;
  logic [31:0] s_rsp_rdata;
  logic [CW-1:0] ost_cnt;
  logic        arb_err;

  int n_chk;
  int n_pass;

  // Reference model: ordered list of masters owed a response, the last grant,
  // the master whose stalled command the slave is currently holding, pending error pulse.
  int ost_q[$];
  bit mdl_last;
  int mdl_held;
  bit mdl_arb;

  int e_win;
  bit e_s_valid;
  bit e_cmd_ready [2];
  bit e_rsp_valid [2];
  bit e_s_rsp_ready;
  bit e_push;
  bit e_pop;
  bit e_arb_next;
  int e_cnt;

  dma_icb_arb #(.OSTD_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_icb_cmd_valid(m_cmd_valid[0]), .m0_icb_cmd_read(m_cmd_read[0]),
    .m0_icb_cmd_addr(m_cmd_addr[0]), .m0_icb_cmd_wdata(m_cmd_wdata[0]),
    .m0_icb_cmd_wmask(m_cmd_wmask[0]), .m0_icb_cmd_ready(m_cmd_ready[0]),
    .m0_icb_rsp_valid(m_rsp_valid[0]), .m0_icb_rsp_rdata(m_rsp_rdata[0]),
    .m0_icb_rsp_err(m_rsp_err[0]), .m0_icb_rsp_ready(m_rsp_ready[0]),
    .m1_icb_cmd_valid(m_cmd_valid[1]), .m1_icb_cmd_read(m_cmd_read[1]),
    .m1_icb_cmd_addr(m_cmd_addr[1]), .m1_icb_cmd_wdata(m_cmd_wdata[1]),
    .m1_icb_cmd_wmask(m_cmd_wmask[1]), .m1_icb_cmd_ready(m_cmd_ready[1]),
    .m1_icb_rsp_valid(m_rsp_valid[1]), .m1_icb_rsp_rdata(m_rsp_rdata[1]),
    .m1_icb_rsp_err(m_rsp_err[1]), .m1_icb_rsp_ready(m_rsp_ready[1]),
    .s_icb_cmd_valid(s_cmd_valid), .s_icb_cmd_read(s_cmd_read),
    .s_icb_cmd_addr(s_cmd_addr), .s_icb_cmd_wdata(s_cmd_wdata),
    .s_icb_cmd_wmask(s_cmd_wmask), .s_icb_cmd_ready(s_cmd_ready),
    .s_icb_rsp_valid(s_rsp_valid), .s_icb_rsp_err(s_rsp_err),
    .s_icb_rsp_rdata(s_rsp_rdata), .s_icb_rsp_ready(s_rsp_ready),
    .ost_cnt(ost_cnt), .arb_err(arb_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic void model_reset();
    ost_q.delete();
    mdl_last = 1'b1;
    mdl_held = -1;
    mdl_arb  = 1'b0;
  endfunction

  function automatic void model_eval();
    bit full;
    int head;
    full = (ost_q.size() == DEPTH);
    if (mdl_held >= 0)                       e_win = mdl_held;
    else if (m_cmd_valid[0] && m_cmd_valid[1]) e_win = mdl_last ? 0 : 1;
    else if (m_cmd_valid[0])                 e_win = 0;
    else if (m_cmd_valid[1])                 e_win = 1;
    else                                     e_win = -1;
    e_s_valid = (e_win >= 0) && m_cmd_valid[e_win] && !full;
    for (int x = 0; x < 2; x++)
      e_cmd_ready[x] = (e_win == x) && m_cmd_valid[x] && s_cmd_ready && !full;
    e_push = e_s_valid && s_cmd_ready;
    e_rsp_valid[0] = 1'b0;
    e_rsp_valid[1] = 1'b0;
    if (ost_q.size() == 0) begin
      e_s_rsp_ready = 1'b1;
      e_pop         = 1'b0;
      e_arb_next    = s_rsp_valid;
    end else begin
      head = ost_q[0];
      e_rsp_valid[head] = s_rsp_valid;
      e_s_rsp_ready     = m_rsp_ready[head];
      e_pop             = s_rsp_valid && m_rsp_ready[head];
      e_arb_next        = 1'b0;
    end
    e_cnt = ost_q.size();
  endfunction

  task automatic model_advance();
    @(posedge clk);
    if (e_pop) void'(ost_q.pop_front());
    if (e_push) begin
      ost_q.push_back(e_win);
      mdl_last = e_win[0];
      mdl_held = -1;
    end else if (e_s_valid) begin
      mdl_held = e_win;
    end
    mdl_arb = e_arb_next;
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    for (int x = 0; x < 2; x++) begin
      m_cmd_valid[x] = 1'b0;
      m_cmd_read[x]  = 1'b0;
      m_cmd_addr[x]  = '0;
      m_cmd_wdata[x] = '0;
      m_cmd_wmask[x] = '0;
      m_rsp_ready[x] = 1'b1;
    end
    s_cmd_ready = 1'b1;
    s_rsp_valid = 1'b0;
    s_rsp_err   = 1'b0;
    s_rsp_rdata = '0;
  endtask

  task automatic set_cmd(input int x, input logic [31:0] addr);
    m_cmd_valid[x] = 1'b1;
    m_cmd_read[x]  = $urandom_range(0, 1);
    m_cmd_addr[x]  = addr;
    m_cmd_wdata[x] = $urandom();
    m_cmd_wmask[x] = $urandom_range(0, 15);
  endtask

  task automatic drain();
    int guard;
    m_cmd_valid[0] = 1'b0;
    m_cmd_valid[1] = 1'b0;
    m_rsp_ready[0] = 1'b1;
    m_rsp_ready[1] = 1'b1;
    guard = 0;
    while (ost_q.size() != 0 && guard < 20) begin
      s_rsp_valid = 1'b1;
      s_rsp_rdata = $urandom();
      @(negedge clk);
      model_eval();
      model_advance();
      guard++;
    end
    s_rsp_valid = 1'b0;
    @(negedge clk);
    model_eval();
    n_chk++; if (ost_cnt !== '0) $display("FAIL drain_ost_cnt got=%0d exp=0", ost_cnt); else n_pass++;
    model_advance();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_chk++; if (s_cmd_valid !== 1'b0) $display("FAIL reset_s_cmd_valid got=%b exp=0", s_cmd_valid); else n_pass++;
    n_chk++; if ({m_cmd_ready[0], m_cmd_ready[1]} !== 2'b00) $display("FAIL reset_cmd_ready got=%b%b exp=00", m_cmd_ready[0], m_cmd_ready[1]); else n_pass++;
    n_chk++; if ({m_rsp_valid[0], m_rsp_valid[1]} !== 2'b00) $display("FAIL reset_rsp_valid got=%b%b exp=00", m_rsp_valid[0], m_rsp_valid[1]); else n_pass++;
    n_chk++; if (ost_cnt !== '0) $display("FAIL reset_ost_cnt got=%0d exp=0", ost_cnt); else n_pass++;
    n_chk++; if (arb_err !== 1'b0) $display("FAIL reset_arb_err got=%b exp=0", arb_err); else n_pass++;
    n_chk++; if (s_rsp_ready !== 1'b1) $display("FAIL reset_s_rsp_ready got=%b exp=1", s_rsp_ready); else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_alternate();
    logic [31:0] exp_addr;
    set_cmd(0, 32'h1000);
    set_cmd(1, 32'h2000);
    m_cmd_read[0] = 1'b1;
    m_cmd_read[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_rsp_valid = (ost_q.size() != 0);
      s_rsp_rdata = $urandom();
      @(negedge clk);
      model_eval();
      exp_addr = (i % 2 == 0) ? 32'h1000 : 32'h2000;
      n_chk++; if (s_cmd_valid !== 1'b1) $display("FAIL alt_s_cmd_valid i=%0d got=%b exp=1", i, s_cmd_valid); else n_pass++;
      n_chk++; if (s_cmd_addr !== exp_addr) $display("FAIL alt_addr i=%0d got=%h exp=%h", i, s_cmd_addr, exp_addr); else n_pass++;
      n_chk++; if (ost_cnt !== CW'(i == 0 ? 0 : 1)) $display("FAIL alt_ost_cnt i=%0d got=%0d exp=%0d", i, ost_cnt, (i == 0 ? 0 : 1)); else n_pass++;
      model_advance();
    end
  endtask

  task automatic test_lock();
    s_rsp_valid = 1'b0;
    m_cmd_valid[0] = 1'b0;
    set_cmd(1, 32'h2468);
    s_cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) set_cmd(0, 32'h1357);
      @(negedge clk);
      model_eval();
      n_chk++; if (s_cmd_addr !== 32'h2468) $display("FAIL lock_addr i=%0d got=%h exp=00002468", i, s_cmd_addr); else n_pass++;
      n_chk++; if (m_cmd_ready[0] !== 1'b0) $display("FAIL lock_m0_ready i=%0d got=%b exp=0", i, m_cmd_ready[0]); else n_pass++;
      n_chk++; if (s_cmd_valid !== 1'b1) $display("FAIL lock_s_valid i=%0d got=%b exp=1", i, s_cmd_valid); else n_pass++;
      model_advance();
    end
    s_cmd_ready = 1'b1;
    @(negedge clk);
    model_eval();
    n_chk++; if (s_cmd_addr !== 32'h2468) $display("FAIL lock_release_addr got=%h exp=00002468", s_cmd_addr); else n_pass++;
    n_chk++; if ({m_cmd_ready[0], m_cmd_ready[1]} !== 2'b01) $display("FAIL lock_release_ready got=%b%b exp=01", m_cmd_ready[0], m_cmd_ready[1]); else n_pass++;
    model_advance();
    set_cmd(1, 32'h2AAA);
    @(negedge clk);
    model_eval();
    n_chk++; if (s_cmd_addr !== 32'h1357) $display("FAIL lock_next_addr got=%h exp=00001357", s_cmd_addr); else n_pass++;
    n_chk++; if ({m_cmd_ready[0], m_cmd_ready[1]} !== 2'b10) $display("FAIL lock_next_ready got=%b%b exp=10", m_cmd_ready[0], m_cmd_ready[1]); else n_pass++;
    model_advance();
    m_cmd_valid[0] = 1'b0;
    @(negedge clk);
    model_eval();
    n_chk++; if (s_cmd_addr !== 32'h2AAA) $display("FAIL lock_m1_again_addr got=%h exp=00002aaa", s_cmd_addr); else n_pass++;
    model_advance();
  endtask

  task automatic test_full();
    s_rsp_valid = 1'b0;
    s_cmd_ready = 1'b1;
    set_cmd(0, $urandom());
    set_cmd(1, $urandom());
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      model_eval();
      n_chk++; if (s_cmd_valid !== 1'b1) $display("FAIL full_fill_valid i=%0d got=%b exp=1", i, s_cmd_valid); else n_pass++;
      n_chk++; if (ost_cnt !== CW'(i)) $display("FAIL full_fill_cnt i=%0d got=%0d exp=%0d", i, ost_cnt, i); else n_pass++;
      model_advance();
      for (int x = 0; x < 2; x++) if (e_cmd_ready[x]) set_cmd(x, $urandom());
    end
    @(negedge clk);
    model_eval();
    n_chk++; if (ost_cnt !== CW'(4)) $display("FAIL full_cnt got=%0d exp=4", ost_cnt); else n_pass++;
    n_chk++; if (s_cmd_valid !== 1'b0) $display("FAIL full_s_valid got=%b exp=0", s_cmd_valid); else n_pass++;
    n_chk++; if ({m_cmd_ready[0], m_cmd_ready[1]} !== 2'b00) $display("FAIL full_ready got=%b%b exp=00", m_cmd_ready[0], m_cmd_ready[1]); else n_pass++;
    model_advance();
    s_rsp_valid = 1'b1;
    @(negedge clk);
    model_eval();
    n_chk++; if (s_cmd_valid !== 1'b0) $display("FAIL full_no_bypass got=%b exp=0", s_cmd_valid); else n_pass++;
    n_chk++; if (s_rsp_ready !== 1'b1) $display("FAIL full_pop_ready got=%b exp=1", s_rsp_ready); else n_pass++;
    model_advance();
    s_rsp_valid = 1'b0;
    @(negedge clk);
    model_eval();
    n_chk++; if (ost_cnt !== CW'(3)) $display("FAIL full_after_pop_cnt got=%0d exp=3", ost_cnt); else n_pass++;
    n_chk++; if (s_cmd_valid !== 1'b1) $display("FAIL full_reissue_valid got=%b exp=1", s_cmd_valid); else n_pass++;
    model_advance();
    m_cmd_valid[0] = 1'b0;
    m_cmd_valid[1] = 1'b0;
    @(negedge clk);
    model_eval();
    n_chk++; if (ost_cnt !== CW'(4)) $display("FAIL full_refill_cnt got=%0d exp=4", ost_cnt); else n_pass++;
    model_advance();
  endtask

  task automatic test_order();
    int          dest  [3] = '{0, 1, 0};
    logic [31:0] rdata [3] = '{32'hA, 32'hB, 32'hC};
    logic        err   [3] = '{1'b0, 1'b1, 1'b0};
    int          d;
    s_rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_cmd_valid[0] = 1'b0;
      m_cmd_valid[1] = 1'b0;
      set_cmd(dest[k], 32'h3000 + 32'(k));
      @(negedge clk);
      model_eval();
      model_advance();
    end
    m_cmd_valid[0] = 1'b0;
    m_cmd_valid[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d = dest[k];
      s_rsp_valid = 1'b1;
      s_rsp_rdata = rdata[k];
      s_rsp_err   = err[k];
      @(negedge clk);
      model_eval();
      n_chk++; if (m_rsp_valid[d] !== 1'b1 || m_rsp_valid[1-d] !== 1'b0) $display("FAIL order_valid k=%0d got=%b%b exp_dest=m%0d", k, m_rsp_valid[0], m_rsp_valid[1], d); else n_pass++;
      n_chk++; if (m_rsp_rdata[d] !== rdata[k]) $display("FAIL order_rdata k=%0d got=%h exp=%h", k, m_rsp_rdata[d], rdata[k]); else n_pass++;
      n_chk++; if (m_rsp_err[d] !== err[k]) $display("FAIL order_err k=%0d got=%b exp=%b", k, m_rsp_err[d], err[k]); else n_pass++;
      model_advance();
    end
    s_rsp_valid = 1'b0;
    s_rsp_err   = 1'b0;
    @(negedge clk);
    model_eval();
    n_chk++; if (ost_cnt !== '0) $display("FAIL order_final_cnt got=%0d exp=0", ost_cnt); else n_pass++;
    model_advance();
  endtask

  task automatic test_rsp_hold();
    set_cmd(1, 32'h4000);
    @(negedge clk);
    model_eval();
    model_advance();
    m_cmd_valid[1] = 1'b0;
    s_rsp_valid    = 1'b1;
    s_rsp_rdata    = 32'h55;
    m_rsp_ready[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      model_eval();
      n_chk++; if (s_rsp_ready !== 1'b0) $display("FAIL hold_s_rsp_ready i=%0d got=%b exp=0", i, s_rsp_ready); else n_pass++;
      n_chk++; if ({m_rsp_valid[0], m_rsp_valid[1]} !== 2'b01) $display("FAIL hold_rsp_valid i=%0d got=%b%b exp=01", i, m_rsp_valid[0], m_rsp_valid[1]); else n_pass++;
      n_chk++; if (ost_cnt !== CW'(1)) $display("FAIL hold_cnt i=%0d got=%0d exp=1", i, ost_cnt); else n_pass++;
      model_advance();
    end
    m_rsp_ready[1] = 1'b1;
    @(negedge clk);
    model_eval();
    n_chk++; if (s_rsp_ready !== 1'b1) $display("FAIL hold_release_ready got=%b exp=1", s_rsp_ready); else n_pass++;
    model_advance();
    s_rsp_valid = 1'b0;
    @(negedge clk);
    model_eval();
    n_chk++; if (ost_cnt !== '0) $display("FAIL hold_popped_cnt got=%0d exp=0", ost_cnt); else n_pass++;
    n_chk++; if (arb_err !== 1'b0) $display("FAIL hold_no_arb_err got=%b exp=0", arb_err); else n_pass++;
    model_advance();
    s_rsp_valid = 1'b1;
    @(negedge clk);
    model_eval();
    n_chk++; if (s_rsp_ready !== 1'b1) $display("FAIL stray_s_rsp_ready got=%b exp=1", s_rsp_ready); else n_pass++;
    n_chk++; if ({m_rsp_valid[0], m_rsp_valid[1]} !== 2'b00) $display("FAIL stray_rsp_valid got=%b%b exp=00", m_rsp_valid[0], m_rsp_valid[1]); else n_pass++;
    model_advance();
    s_rsp_valid = 1'b0;
    @(negedge clk);
    model_eval();
    n_chk++; if (arb_err !== 1'b1) $display("FAIL stray_arb_err_pulse got=%b exp=1", arb_err); else n_pass++;
    model_advance();
    @(negedge clk);
    model_eval();
    n_chk++; if (arb_err !== 1'b0) $display("FAIL stray_arb_err_clear got=%b exp=0", arb_err); else n_pass++;
    model_advance();
  endtask

  task automatic test_random();
    logic [68:0] exp_cmd;
    m_cmd_valid[0] = 1'b0;
    m_cmd_valid[1] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      s_cmd_ready    = ($urandom_range(0, 3) != 0);
      s_rsp_valid    = ($urandom_range(0, 2) != 0);
      s_rsp_rdata    = $urandom();
      s_rsp_err      = $urandom_range(0, 1);
      m_rsp_ready[0] = ($urandom_range(0, 3) != 0);
      m_rsp_ready[1] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      model_eval();
      n_chk++; if (s_cmd_valid !== e_s_valid) $display("FAIL rnd_s_cmd_valid c=%0d got=%b exp=%b", c, s_cmd_valid, e_s_valid); else n_pass++;
      if (e_s_valid) begin
        exp_cmd = {m_cmd_read[e_win], m_cmd_addr[e_win], m_cmd_wdata[e_win], m_cmd_wmask[e_win]};
        n_chk++; if ({s_cmd_read, s_cmd_addr, s_cmd_wdata, s_cmd_wmask} !== exp_cmd) $display("FAIL rnd_cmd_payload c=%0d got=%h exp=%h", c, {s_cmd_read, s_cmd_addr, s_cmd_wdata, s_cmd_wmask}, exp_cmd); else n_pass++;
      end
      for (int x = 0; x < 2; x++) begin
        n_chk++; if (m_cmd_ready[x] !== e_cmd_ready[x]) $display("FAIL rnd_cmd_ready m%0d c=%0d got=%b exp=%b", x, c, m_cmd_ready[x], e_cmd_ready[x]); else n_pass++;
        n_chk++; if (m_rsp_valid[x] !== e_rsp_valid[x]) $display("FAIL rnd_rsp_valid m%0d c=%0d got=%b exp=%b", x, c, m_rsp_valid[x], e_rsp_valid[x]); else n_pass++;
        if (e_rsp_valid[x]) begin
          n_chk++; if ({m_rsp_err[x], m_rsp_rdata[x]} !== {s_rsp_err, s_rsp_rdata}) $display("FAIL rnd_rsp_data m%0d c=%0d got=%h exp=%h", x, c, {m_rsp_err[x], m_rsp_rdata[x]}, {s_rsp_err, s_rsp_rdata}); else n_pass++;
        end
      end
      n_chk++; if (s_rsp_ready !== e_s_rsp_ready) $display("FAIL rnd_s_rsp_ready c=%0d got=%b exp=%b", c, s_rsp_ready, e_s_rsp_ready); else n_pass++;
      n_chk++; if (ost_cnt !== CW'(e_cnt)) $display("FAIL rnd_ost_cnt c=%0d got=%0d exp=%0d", c, ost_cnt, e_cnt); else n_pass++;
      n_chk++; if (arb_err !== mdl_arb) $display("FAIL rnd_arb_err c=%0d got=%b exp=%b", c, arb_err, mdl_arb); else n_pass++;
      model_advance();
      for (int x = 0; x < 2; x++) begin
        if (!m_cmd_valid[x] || e_cmd_ready[x]) begin
          if ($urandom_range(0, 2) != 0) set_cmd(x, $urandom());
          else m_cmd_valid[x] = 1'b0;
        end
      end
    end
    s_rsp_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    s_rsp_valid = 1'b0;
    s_cmd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m_cmd_valid[0] = 1'b0;
      m_cmd_valid[1] = 1'b0;
      set_cmd(k % 2, 32'h5000 + 32'(k));
      @(negedge clk);
      model_eval();
      model_advance();
    end
    m_cmd_valid[0] = 1'b0;
    set_cmd(1, 32'h5100);
    s_cmd_ready = 1'b0;
    @(negedge clk);
    model_eval();
    n_chk++; if (ost_cnt !== CW'(3)) $display("FAIL rstmid_pre_cnt got=%0d exp=3", ost_cnt); else n_pass++;
    model_advance();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    n_chk++; if (ost_cnt !== '0) $display("FAIL rstmid_cnt got=%0d exp=0", ost_cnt); else n_pass++;
    n_chk++; if (s_cmd_valid !== 1'b0) $display("FAIL rstmid_s_valid got=%b exp=0", s_cmd_valid); else n_pass++;
    n_chk++; if (arb_err !== 1'b0) $display("FAIL rstmid_arb_err got=%b exp=0", arb_err); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_cmd(0, 32'hA000);
    set_cmd(1, 32'hB000);
    @(negedge clk);
    model_eval();
    n_chk++; if (s_cmd_addr !== 32'hA000) $display("FAIL rstmid_first_grant_addr got=%h exp=0000a000", s_cmd_addr); else n_pass++;
    n_chk++; if ({m_cmd_ready[0], m_cmd_ready[1]} !== 2'b10) $display("FAIL rstmid_first_grant_ready got=%b%b exp=10", m_cmd_ready[0], m_cmd_ready[1]); else n_pass++;
    model_advance();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b1;
    idle_inputs();
    model_reset();
    #1 rst_n = 1'b0;
    test_reset();
    test_alternate();
    drain();
    test_lock();
    drain();
    test_full();
    drain();
    test_order();
    test_rsp_hold();
    test_random();
    drain();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
